// File: rtl/dbg_bus_master.sv
// Debug-port bus master: queues {sel, word} debug writes in a FIFO and replays
// them as single-beat reads/writes on one master port, with sticky error flags.
module dbg_bus_master #(
    parameter int FIFO_AW        = 5,
    parameter int ADDR_STEP      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk48m,
    input  logic              rst,
    input  logic [31:0]       dbgreg_in,
    input  logic              dbgreg_sel,
    input  logic              dbgreg_strobe,
    input  logic              flag_clr,
    output logic [31:0]       dbgreg_out,
    output logic [31:0]       m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    output logic              timeout_err
);
    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [31:0]     TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [32:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [32:0]        head;
    logic               pop, push, done, tmo;
    logic [31:0]        addr;
    logic [1:0]         mode;
    logic [31:0]        timer;

    assign head = mem[rd_ptr];
    assign pop  = (state == IDLE) && (fifo_level != '0);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push = dbgreg_strobe && ((fifo_level != FULL) || pop);
    assign done = (state == ACCESS) && m_ready;
    assign tmo  = (state == ACCESS) && !m_ready && (TIMEOUT_CYCLES != 0) && (timer == TMO_LAST);
    assign busy = (fifo_level != '0) || (state != IDLE);

    always_ff @(posedge clk48m) begin
        if (push) mem[wr_ptr] <= {dbgreg_sel, dbgreg_in};
    end

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (dbgreg_strobe && !push) overflow <= 1'b1;
            else if (flag_clr)          overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop && !head[32]) state_nxt = ACCESS;
            ACCESS:  if (done || tmo)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            mode        <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_valid     <= 1'b0;
            dbgreg_out  <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                if (head[32]) begin
                    addr <= {head[31:2], 2'b00};
                    mode <= head[1:0];
                end else begin
                    m_addr  <= addr;
                    m_wdata <= head[31:0];
                    m_wstrb <= mode[0] ? 4'h0 : 4'hf;
                    m_valid <= 1'b1;
                    timer   <= '0;
                end
            end
            if (done) begin
                m_valid <= 1'b0;
                if (mode[0])  dbgreg_out <= m_rdata;
                if (!mode[1]) addr <= addr + 32'(ADDR_STEP);
            end else if (tmo) begin
                m_valid <= 1'b0;
            end else if (state == ACCESS) begin
                timer <= timer + 32'd1;
            end
            if (tmo)           timeout_err <= 1'b1;
            else if (flag_clr) timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: directed vector table, multi-cycle corner sequences,
// then random command streams against a queue-based reference model.
module tb_dbg_bus_master;
    localparam int AW = 5;

    logic        clk48m = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dbgreg_in = '0;
    logic        dbgreg_sel = 1'b0;
    logic        dbgreg_strobe = 1'b0;
    logic        flag_clr = 1'b0;
    logic [31:0] dbgreg_out, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy;
    logic [AW:0] fifo_level;
    logic        overflow, timeout_err;

    logic        strobe2 = 1'b0;
    logic        flag_clr2 = 1'b0;
    logic        m_ready2 = 1'b0;
    logic [31:0] m_rdata2 = '0;
    logic [31:0] dbgreg_out2, m_addr2, m_wdata2;
    logic [3:0]  m_wstrb2;
    logic        m_valid2, busy2, overflow2, timeout_err2;
    logic [AW:0] fifo_level2;

    dbg_bus_master #(.FIFO_AW(AW), .ADDR_STEP(4), .TIMEOUT_CYCLES(8)) u_dut (
        .clk48m(clk48m), .rst(rst), .dbgreg_in(dbgreg_in), .dbgreg_sel(dbgreg_sel),
        .dbgreg_strobe(dbgreg_strobe), .flag_clr(flag_clr), .dbgreg_out(dbgreg_out),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_valid(m_valid),
        .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy), .fifo_level(fifo_level),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    // Second instance never times out, so its FIFO can be filled behind a stalled access.
    dbg_bus_master #(.FIFO_AW(AW), .ADDR_STEP(4), .TIMEOUT_CYCLES(0)) u_dut_nt (
        .clk48m(clk48m), .rst(rst), .dbgreg_in(dbgreg_in), .dbgreg_sel(dbgreg_sel),
        .dbgreg_strobe(strobe2), .flag_clr(flag_clr2), .dbgreg_out(dbgreg_out2),
        .m_addr(m_addr2), .m_wdata(m_wdata2), .m_wstrb(m_wstrb2), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_rdata(m_rdata2), .busy(busy2), .fifo_level(fifo_level2),
        .overflow(overflow2), .timeout_err(timeout_err2)
    );

    always #10 clk48m = ~clk48m;

    typedef struct {
        logic        sel;
        logic [31:0] word;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_out;
    } vec_t;
    vec_t tbl [10];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk48m);
    endtask

    task automatic push(input logic sel, input logic [31:0] w);
        dbgreg_sel = sel; dbgreg_in = w; dbgreg_strobe = 1'b1;
        cyc();
        dbgreg_strobe = 1'b0;
    endtask

    task automatic push2(input logic sel, input logic [31:0] w);
        dbgreg_sel = sel; dbgreg_in = w; strobe2 = 1'b1;
        cyc();
        strobe2 = 1'b0;
    endtask

    // Wait for a request, check it, answer one cycle later, check the result.
    task automatic do_acc(input string nm, input logic [31:0] ea, input logic [31:0] ew,
                          input logic [3:0] es, input logic [31:0] rd, input logic [31:0] eo);
        int i;
        i = 0;
        while (!m_valid && i < 20) begin cyc(); i++; end
        chk({nm, "_valid"}, m_valid, 1);
        chk({nm, "_addr"}, m_addr, ea);
        chk({nm, "_wstrb"}, m_wstrb, es);
        if (es == 4'hf) chk({nm, "_wdata"}, m_wdata, ew);
        cyc();
        chk({nm, "_hold"}, m_addr, ea);
        m_ready = 1'b1; m_rdata = rd;
        cyc();
        m_ready = 1'b0; m_rdata = '0;
        chk({nm, "_drop"}, m_valid, 0);
        chk({nm, "_out"}, dbgreg_out, eo);
    endtask

    logic [32:0] q[$];
    logic [32:0] w;
    logic [31:0] maddr, mout;
    logic [1:0]  mmode;
    logic        cur_rd;
    bit          in_acc, hs, saw_to, fin;
    int          vcnt, lat, pushed, n, left;

    initial begin
        tbl[0] = '{1'b1, 32'h40000000, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0};
        tbl[1] = '{1'b0, 32'hAAAA0001, 32'hBAD0BAD0, 32'h40000000, 32'hAAAA0001, 4'hf, 32'h0};
        tbl[2] = '{1'b0, 32'hBBBB0002, 32'hBAD0BAD1, 32'h40000004, 32'hBBBB0002, 4'hf, 32'h0};
        tbl[3] = '{1'b0, 32'hCCCC0003, 32'hBAD0BAD2, 32'h40000008, 32'hCCCC0003, 4'hf, 32'h0};
        tbl[4] = '{1'b1, 32'h40000103, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0};
        tbl[5] = '{1'b0, 32'hDEAD0000, 32'h00001234, 32'h40000100, 32'h0,        4'h0, 32'h00001234};
        tbl[6] = '{1'b0, 32'hDEAD0001, 32'h00005678, 32'h40000100, 32'h0,        4'h0, 32'h00005678};
        tbl[7] = '{1'b1, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0};
        tbl[8] = '{1'b0, 32'h00000011, 32'hBAD0BAD3, 32'hFFFFFFFC, 32'h00000011, 4'hf, 32'h00005678};
        tbl[9] = '{1'b0, 32'h00000022, 32'hBAD0BAD4, 32'h00000000, 32'h00000022, 4'hf, 32'h00005678};

        repeat (3) cyc();
        chk("rst_valid", m_valid, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wstrb", m_wstrb, 0);
        chk("rst_out", dbgreg_out, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", timeout_err, 0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 10; i++) begin
            push(tbl[i].sel, tbl[i].word);
            if (!tbl[i].sel)
                do_acc($sformatf("v%0d", i), tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_wstrb,
                       tbl[i].rdata, tbl[i].e_out);
        end

        // Timeout: request held exactly 8 cycles, address not advanced afterwards.
        push(1'b1, 32'h80000000);
        push(1'b0, 32'h00000055);
        n = 0;
        while (!m_valid && n < 20) begin cyc(); n++; end
        n = 0;
        while (m_valid && n < 20) begin cyc(); n++; end
        chk("tmo_len", n, 8);
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_out", dbgreg_out, 32'h00005678);
        push(1'b0, 32'h00000066);
        do_acc("tmo_next", 32'h80000000, 32'h00000066, 4'hf, 32'h0, 32'h00005678);
        flag_clr = 1'b1; cyc(); flag_clr = 1'b0;
        chk("tmo_clr", timeout_err, 0);

        // Fill behind a stalled access on the no-timeout instance.
        push2(1'b0, 32'h00000001);
        cyc();
        chk("ovf_stall_valid", m_valid2, 1);
        chk("ovf_stall_level", fifo_level2, 0);
        for (int i = 0; i < 32; i++) push2(1'b0, 32'h100 + 32'(i));
        chk("ovf_full_level", fifo_level2, 32);
        chk("ovf_not_yet", overflow2, 0);
        push2(1'b0, 32'h00000999);
        chk("ovf_level", fifo_level2, 32);
        chk("ovf_flag", overflow2, 1);
        chk("ovf_busy", busy2, 1);
        flag_clr2 = 1'b1; cyc(); flag_clr2 = 1'b0;
        chk("ovf_clr", overflow2, 0);
        dbgreg_sel = 1'b0; strobe2 = 1'b1; flag_clr2 = 1'b1;
        cyc();
        strobe2 = 1'b0; flag_clr2 = 1'b0;
        chk("ovf_set_wins", overflow2, 1);
        flag_clr2 = 1'b1; cyc(); flag_clr2 = 1'b0;
        chk("ovf_clr2", overflow2, 0);
        chk("ovf_clr_level", fifo_level2, 32);

        // Reset in the middle of an access with three words still queued.
        for (int i = 0; i < 4; i++) push(1'b0, 32'h700 + 32'(i));
        chk("mid_valid", m_valid, 1);
        chk("mid_level", fifo_level, 3);
        rst = 1'b1;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_out", dbgreg_out, 0);
        chk("arst_level2", fifo_level2, 0);
        cyc(); cyc();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin cyc(); if (m_valid || busy) n++; end
        chk("post_rst_quiet", n, 0);

        // Random streams against the reference model.
        maddr = '0; mmode = '0; mout = '0; cur_rd = 1'b0;
        in_acc = 0; hs = 0; saw_to = 0; fin = 0;
        vcnt = 0; lat = 0; pushed = 0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            cyc();
            if (pushed == 150 && !busy && !in_acc && !m_valid) begin
                fin = 1;
            end else begin
                if (in_acc && hs) begin
                    chk("rnd_drop", m_valid, 0);
                    chk("rnd_out", dbgreg_out, mout);
                    in_acc = 0; hs = 0;
                end else if (in_acc && !m_valid) begin
                    chk("rnd_tmo_len", vcnt, 8);
                    chk("rnd_tmo_flag", timeout_err, 1);
                    chk("rnd_tmo_out", dbgreg_out, mout);
                    saw_to = 1; in_acc = 0;
                end
                if (m_valid && !in_acc) begin
                    in_acc = 1; vcnt = 0; hs = 0; lat = $urandom_range(0, 9);
                    while (q.size() > 0 && q[0][32]) begin
                        w = q.pop_front();
                        maddr = {w[31:2], 2'b00};
                        mmode = w[1:0];
                    end
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL rnd_spurious: access at 0x%08h with no queued data word", m_addr);
                    end else begin
                        w = q.pop_front();
                        cur_rd = mmode[0];
                        chk("rnd_addr", m_addr, maddr);
                        chk("rnd_wstrb", m_wstrb, cur_rd ? 4'h0 : 4'hf);
                        if (!cur_rd) chk("rnd_wdata", m_wdata, w[31:0]);
                    end
                end
                if (m_valid && in_acc) begin
                    if (vcnt == lat) begin
                        m_ready = 1'b1; m_rdata = $urandom; hs = 1;
                        if (cur_rd) mout = m_rdata;
                        if (!mmode[1]) maddr = maddr + 32'd4;
                    end else begin
                        m_ready = 1'b0;
                    end
                    vcnt++;
                end else begin
                    // Idle-time ready must be ignored.
                    m_ready = 1'($urandom_range(0, 1)); m_rdata = $urandom;
                end
                dbgreg_strobe = 1'b0;
                if (pushed < 150 && $urandom_range(0, 2) == 0 && fifo_level < 24) begin
                    dbgreg_sel = ($urandom_range(0, 3) == 0);
                    dbgreg_in = $urandom;
                    dbgreg_strobe = 1'b1;
                    q.push_back({dbgreg_sel, dbgreg_in});
                    pushed++;
                end
            end
        end
        m_ready = 1'b0;
        chk("rnd_finished", fin, 1);
        left = 0;
        foreach (q[i]) if (!q[i][32]) left++;
        chk("rnd_leftover", left, 0);
        chk("rnd_final_out", dbgreg_out, mout);
        chk("rnd_ovf", overflow, 0);
        chk("rnd_tmo_sticky", timeout_err, saw_to);
        chk("rnd_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
